// File: rtl/rdata_return_mux.sv
// Read-data return mux: steers one slave's read data back to the core, with a bus error on no-select or timeout.
// Response is registered: 1 cycle after a valid slave beat; req is ignored while busy.
module rdata_return_mux #(
  parameter int              NUM_SLV  = 2,
  parameter int              DW       = 32,
  parameter int              TIMEOUT  = 15,
  parameter logic [DW-1:0]   ERR_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [NUM_SLV-1:0]    cs_n,
  input  logic [NUM_SLV-1:0]    slv_rvalid,
  input  logic [NUM_SLV*DW-1:0] slv_rdata,
  output logic [DW-1:0]         rdata,
  output logic                  rvalid,
  output logic                  rerr,
  output logic                  busy
);

  localparam int SW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rerr_q, rerr_d;

  logic [DW-1:0] slv_dat [NUM_SLV];
  logic          any_sel;
  logic [SW-1:0] win_idx;

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_unpack
    assign slv_dat[g] = slv_rdata[g*DW +: DW];
  end

  // Scan from the top down so the lowest active select is the last one written.
  always_comb begin
    any_sel = 1'b0;
    win_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (!cs_n[i]) begin
        any_sel = 1'b1;
        win_idx = SW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rerr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (any_sel) begin
            sel_d = win_idx;
            cnt_d = '0;
            if (slv_rvalid[win_idx]) begin
              rdata_d = slv_dat[win_idx];
              state_d = S_RESP;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            rdata_d = ERR_DATA;
            rerr_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        // A beat on the final allowed cycle still beats the timeout.
        if (slv_rvalid[sel_q]) begin
          rdata_d = slv_dat[sel_q];
          state_d = S_RESP;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            rdata_d = ERR_DATA;
            rerr_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata  = rdata_q;
    rvalid = (state_q == S_RESP);
    rerr   = rerr_q;
    busy   = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_rdata_return_mux.sv
// Bench for rdata_return_mux: directed scenarios plus randomized transactions checked
// against a transaction-level model (winner, first valid cycle, response cycle).
module tb_rdata_return_mux;

  localparam int          NS   = 2;
  localparam int          DW   = 32;
  localparam int          TO   = 15;
  localparam int          NC   = 24;
  localparam logic [31:0] ERRV = 32'hBAD0_0E11;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [1:0]  cs_n;
  logic [1:0]  slv_rvalid;
  logic [63:0] slv_rdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rerr;
  logic        busy;

  rdata_return_mux #(
    .NUM_SLV (NS),
    .DW      (DW),
    .TIMEOUT (TO),
    .ERR_DATA(ERRV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .cs_n      (cs_n),
    .slv_rvalid(slv_rvalid),
    .slv_rdata (slv_rdata),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .rerr      (rerr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle stimulus and captured outputs; cycle 0 is the request cycle.
  logic        st_req [NC];
  logic [1:0]  st_cs  [NC];
  logic [1:0]  st_vld [NC];
  logic [31:0] st_d0  [NC];
  logic [31:0] st_d1  [NC];
  logic        st_rst [NC];
  logic        ob_rv  [NC];
  logic        ob_er  [NC];
  logic        ob_bz  [NC];
  logic [31:0] ob_rd  [NC];

  int          n_checks;
  int          n_pass;
  logic [31:0] model_rdata;

  task automatic clear_stim();
    for (int i = 0; i < NC; i++) begin
      st_req[i] = 1'b0;
      st_cs[i]  = 2'b11;
      st_vld[i] = 2'b00;
      st_d0[i]  = $urandom;
      st_d1[i]  = $urandom;
      st_rst[i] = 1'b0;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_txn(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      req        = st_req[c];
      cs_n       = st_cs[c];
      slv_rvalid = st_vld[c];
      slv_rdata  = {st_d1[c], st_d0[c]};
      rst_n      = !st_rst[c];
      @(negedge clk);
      ob_rv[c] = rvalid;
      ob_er[c] = rerr;
      ob_bz[c] = busy;
      ob_rd[c] = rdata;
      @(posedge clk);
      #1;
    end
    req        = 1'b0;
    cs_n       = 2'b11;
    slv_rvalid = 2'b00;
    rst_n      = 1'b1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req        = 1'b1;
    cs_n       = 2'b10;
    slv_rvalid = 2'b01;
    slv_rdata  = {$urandom, $urandom};
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got %0b exp 0", rvalid); else n_pass++;
    n_checks++; if (rerr !== 1'b0) $display("FAIL reset_rerr got %0b exp 0", rerr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rdata); else n_pass++;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    req        = 1'b0;
    cs_n       = 2'b11;
    slv_rvalid = 2'b00;
    model_rdata = 32'h0;
  endtask

  task automatic test_dmem_comb();
    clear_stim();
    st_req[0] = 1'b1; st_cs[0] = 2'b10; st_vld[0] = 2'b01; st_d0[0] = 32'h1234_5678;
    run_txn(3);
    n_checks++; if (ob_rv[0] !== 1'b0) $display("FAIL dmem_rvalid_c0 got %0b exp 0", ob_rv[0]); else n_pass++;
    n_checks++; if (ob_rv[1] !== 1'b1) $display("FAIL dmem_rvalid_c1 got %0b exp 1", ob_rv[1]); else n_pass++;
    n_checks++; if (ob_er[1] !== 1'b0) $display("FAIL dmem_rerr got %0b exp 0", ob_er[1]); else n_pass++;
    n_checks++; if (ob_rd[1] !== 32'h1234_5678) $display("FAIL dmem_rdata got %h exp 12345678", ob_rd[1]); else n_pass++;
    n_checks++; if (ob_bz[1] !== 1'b1) $display("FAIL dmem_busy_c1 got %0b exp 1", ob_bz[1]); else n_pass++;
    n_checks++; if (ob_bz[2] !== 1'b0) $display("FAIL dmem_busy_c2 got %0b exp 0", ob_bz[2]); else n_pass++;
    n_checks++; if (ob_rv[2] !== 1'b0) $display("FAIL dmem_rvalid_c2 got %0b exp 0", ob_rv[2]); else n_pass++;
    model_rdata = 32'h1234_5678;
  endtask

  task automatic test_tbman_delayed();
    clear_stim();
    st_req[0] = 1'b1; st_cs[0] = 2'b01;
    st_vld[2] = 2'b01;
    st_vld[3] = 2'b10; st_d1[3] = 32'hCAFE_0001;
    run_txn(6);
    n_checks++; if (ob_rv[3] !== 1'b0) $display("FAIL tbman_rvalid_c3 got %0b exp 0", ob_rv[3]); else n_pass++;
    n_checks++; if (ob_rd[3] !== model_rdata) $display("FAIL tbman_hold_c3 got %h exp %h", ob_rd[3], model_rdata); else n_pass++;
    n_checks++; if (ob_rv[4] !== 1'b1) $display("FAIL tbman_rvalid_c4 got %0b exp 1", ob_rv[4]); else n_pass++;
    n_checks++; if (ob_rd[4] !== 32'hCAFE_0001) $display("FAIL tbman_rdata got %h exp cafe0001", ob_rd[4]); else n_pass++;
    n_checks++; if (ob_er[4] !== 1'b0) $display("FAIL tbman_rerr got %0b exp 0", ob_er[4]); else n_pass++;
    model_rdata = 32'hCAFE_0001;
  endtask

  task automatic test_both_sel();
    clear_stim();
    st_req[0] = 1'b1; st_cs[0] = 2'b00; st_vld[0] = 2'b11;
    st_d0[0] = 32'hA; st_d1[0] = 32'hB;
    run_txn(3);
    n_checks++; if (ob_rv[1] !== 1'b1) $display("FAIL both_rvalid got %0b exp 1", ob_rv[1]); else n_pass++;
    n_checks++; if (ob_rd[1] !== 32'hA) $display("FAIL both_rdata got %h exp a", ob_rd[1]); else n_pass++;
    model_rdata = 32'hA;
  endtask

  task automatic test_no_sel();
    clear_stim();
    st_req[0] = 1'b1; st_cs[0] = 2'b11; st_vld[0] = 2'b11;
    run_txn(3);
    n_checks++; if (ob_rv[1] !== 1'b1) $display("FAIL nosel_rvalid got %0b exp 1", ob_rv[1]); else n_pass++;
    n_checks++; if (ob_er[1] !== 1'b1) $display("FAIL nosel_rerr got %0b exp 1", ob_er[1]); else n_pass++;
    n_checks++; if (ob_rd[1] !== ERRV) $display("FAIL nosel_rdata got %h exp %h", ob_rd[1], ERRV); else n_pass++;
    n_checks++; if (ob_er[2] !== 1'b0) $display("FAIL nosel_rerr_c2 got %0b exp 0", ob_er[2]); else n_pass++;
    model_rdata = ERRV;
  endtask

  task automatic test_idle_ignore();
    clear_stim();
    for (int c = 0; c < 4; c++) st_vld[c] = 2'b11;
    run_txn(4);
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (ob_rv[c] !== 1'b0) $display("FAIL idle_rvalid c%0d got %0b exp 0", c, ob_rv[c]); else n_pass++;
      n_checks++; if (ob_rd[c] !== model_rdata) $display("FAIL idle_rdata c%0d got %h exp %h", c, ob_rd[c], model_rdata); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    clear_stim();
    st_req[0] = 1'b1; st_cs[0] = 2'b10;
    run_txn(18);
    n_checks++; if (ob_rv[TO] !== 1'b0) $display("FAIL to_rvalid_early got %0b exp 0", ob_rv[TO]); else n_pass++;
    n_checks++; if (ob_bz[TO] !== 1'b1) $display("FAIL to_busy got %0b exp 1", ob_bz[TO]); else n_pass++;
    n_checks++; if (ob_rv[TO+1] !== 1'b1) $display("FAIL to_rvalid got %0b exp 1", ob_rv[TO+1]); else n_pass++;
    n_checks++; if (ob_er[TO+1] !== 1'b1) $display("FAIL to_rerr got %0b exp 1", ob_er[TO+1]); else n_pass++;
    n_checks++; if (ob_rd[TO+1] !== ERRV) $display("FAIL to_rdata got %h exp %h", ob_rd[TO+1], ERRV); else n_pass++;
    n_checks++; if (ob_bz[TO+2] !== 1'b0) $display("FAIL to_busy_after got %0b exp 0", ob_bz[TO+2]); else n_pass++;
    clear_stim();
    st_req[0] = 1'b1; st_cs[0] = 2'b10; st_vld[TO] = 2'b01; st_d0[TO] = 32'h5EED_0F0F;
    run_txn(18);
    n_checks++; if (ob_rv[TO+1] !== 1'b1) $display("FAIL tolast_rvalid got %0b exp 1", ob_rv[TO+1]); else n_pass++;
    n_checks++; if (ob_er[TO+1] !== 1'b0) $display("FAIL tolast_rerr got %0b exp 0", ob_er[TO+1]); else n_pass++;
    n_checks++; if (ob_rd[TO+1] !== 32'h5EED_0F0F) $display("FAIL tolast_rdata got %h exp 5eed0f0f", ob_rd[TO+1]); else n_pass++;
    model_rdata = 32'h5EED_0F0F;
  endtask

  task automatic test_reset_in_wait();
    clear_stim();
    st_req[0] = 1'b1; st_cs[0] = 2'b10;
    st_rst[2] = 1'b1; st_rst[3] = 1'b1;
    st_vld[4] = 2'b01; st_vld[5] = 2'b01;
    run_txn(9);
    n_checks++; if (ob_bz[1] !== 1'b1) $display("FAIL rstw_busy_c1 got %0b exp 1", ob_bz[1]); else n_pass++;
    n_checks++; if (ob_bz[2] !== 1'b0) $display("FAIL rstw_busy_c2 got %0b exp 0", ob_bz[2]); else n_pass++;
    n_checks++; if (ob_rd[4] !== 32'h0) $display("FAIL rstw_rdata got %h exp 0", ob_rd[4]); else n_pass++;
    for (int c = 1; c < 9; c++) begin
      n_checks++; if (ob_rv[c] !== 1'b0) $display("FAIL rstw_rvalid c%0d got %0b exp 0", c, ob_rv[c]); else n_pass++;
    end
    clear_stim();
    st_req[0] = 1'b1; st_cs[0] = 2'b10; st_vld[1] = 2'b01;
    run_txn(4);
    n_checks++; if (ob_rv[2] !== 1'b1) $display("FAIL rstw_next_rvalid got %0b exp 1", ob_rv[2]); else n_pass++;
    n_checks++; if (ob_rd[2] !== st_d0[1]) $display("FAIL rstw_next_rdata got %h exp %h", ob_rd[2], st_d0[1]); else n_pass++;
    model_rdata = st_d0[1];
  endtask

  task automatic test_random(input int ntx);
    logic [1:0]  cs;
    logic [31:0] exp_d;
    logic        exp_err;
    int          k;
    int          win;
    int          resp;
    for (int t = 0; t < ntx; t++) begin
      clear_stim();
      cs  = 2'($urandom_range(0, 3));
      k   = int'($urandom_range(0, TO + 3));
      win = (cs[0] == 1'b0) ? 0 : 1;
      st_req[0] = 1'b1;
      st_cs[0]  = cs;
      for (int c = 0; c < NC; c++) begin
        st_vld[c] = 2'($urandom_range(0, 3));
        if (c < k) st_vld[c][win] = 1'b0;
        if (c == k) st_vld[c][win] = 1'b1;
        if (c > 0) begin
          st_req[c] = 1'($urandom_range(0, 1));
          st_cs[c]  = 2'($urandom_range(0, 3));
        end
      end
      // Model: response one cycle after the first winner beat within the window, else error.
      if (cs == 2'b11) begin
        resp = 1; exp_err = 1'b1; exp_d = ERRV;
      end else begin
        resp = TO + 1; exp_err = 1'b1; exp_d = ERRV;
        for (int c = TO; c >= 0; c--) begin
          if (st_vld[c][win]) begin
            resp = c + 1; exp_err = 1'b0; exp_d = (win == 0) ? st_d0[c] : st_d1[c];
          end
        end
      end
      st_req[resp+1] = 1'b0;
      run_txn(resp + 2);
      for (int c = 0; c < resp + 2; c++) begin
        n_checks++;
        if (ob_rv[c] !== (c == resp) || ob_er[c] !== (c == resp && exp_err) ||
            ob_bz[c] !== (c >= 1 && c <= resp) || ob_rd[c] !== ((c < resp) ? model_rdata : exp_d))
          $display("FAIL rand t%0d c%0d got rv=%0b er=%0b bz=%0b rd=%h exp rv=%0b er=%0b bz=%0b rd=%h",
                   t, c, ob_rv[c], ob_er[c], ob_bz[c], ob_rd[c], (c == resp), (c == resp && exp_err),
                   (c >= 1 && c <= resp), (c < resp) ? model_rdata : exp_d);
        else n_pass++;
      end
      model_rdata = exp_d;
    end
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    model_rdata = 32'h0;
    test_reset();
    test_dmem_comb();
    test_tbman_delayed();
    test_both_sel();
    test_no_sel();
    test_idle_ignore();
    test_timeout();
    test_reset_in_wait();
    test_random(60);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rdata_return_mux.md
RDATA_RETURN_MUX -- requirements
Module: rdata_return_mux

Interface
REQ-001 Parameter NUM_SLV, default 2, number of slave read channels (>=1); channel 0 is data memory, channel 1 is TBMAN.
REQ-002 Parameter DW, default 32, read data width.
REQ-003 Parameter TIMEOUT, default 15, maximum WAIT cycles before a bus error (>=1).
REQ-004 Parameter ERR_DATA, default 0 (DW bits), value returned on rdata with an error response.
REQ-005 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 Port rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-007 Port req  input  1  core read-request strobe, sampled only in IDLE.
REQ-008 Port cs_n  input  NUM_SLV  active-low per-slave chip selects, sampled with req.
REQ-009 Port slv_rvalid  input  NUM_SLV  per-slave read-data-valid.
REQ-010 Port slv_rdata  input  NUM_SLV*DW  packed slave read data; slave i occupies bits [i*DW +: DW].
REQ-011 Port rdata  output  DW  registered read data to the core.
REQ-012 Port rvalid  output  1  registered one-cycle response strobe.
REQ-013 Port rerr  output  1  error flag, meaningful only while rvalid=1.
REQ-014 Port busy  output  1  high in WAIT and RESP; req is ignored while busy=1.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 Select decode: the lowest index i with cs_n[i]=0 wins; when several selects are low, higher indices are ignored.
REQ-017 IDLE, req=1, at least one select low: latch the winning index (sel_q); clear the timeout counter.
REQ-018 If slv_rvalid[sel] is also 1 in that same cycle: capture slv_rdata[sel] and go to RESP (1-cycle latency); otherwise go to WAIT.
REQ-019 IDLE, req=1, all cs_n high: go to RESP with an error response (rdata=ERR_DATA, rerr=1).
REQ-020 IDLE, req=0: remain in IDLE; slv_rvalid is ignored.
REQ-021 WAIT, slv_rvalid[sel_q]=1: capture slv_rdata[sel_q] and go to RESP, rerr=0.
REQ-022 WAIT: slv_rvalid from any other slave is ignored.
REQ-023 WAIT without valid: the counter increments; width is $clog2(TIMEOUT+1) and the counter saturates, never wraps.
REQ-024 Timeout: on the TIMEOUT-th WAIT cycle with no valid, go to RESP with an error response.
REQ-025 Timeout response timing: for req at cycle 0, the error rvalid is at cycle TIMEOUT+1.
REQ-026 Timeout boundary: if slv_rvalid[sel_q] arrives on the final (TIMEOUT-th) WAIT cycle, data wins and rerr=0.
REQ-027 RESP: rvalid=1 for exactly one cycle, then return to IDLE; req during RESP is dropped.
REQ-028 Data response latency: slave valid at cycle k gives rvalid at cycle k+1.
REQ-029 rdata holds its last captured value between responses.
REQ-030 rvalid and rerr are 0 in all states other than RESP.
REQ-031 Changes to cs_n while in WAIT have no effect; only sel_q is used.

Reset
REQ-032 While rst_n=0: state=IDLE; rdata=0; rvalid=0; rerr=0; busy=0; sel_q=0; counter=0.
REQ-033 Reset asserted mid-WAIT or mid-RESP abandons the transaction; no rvalid is produced after release.
REQ-034 The first cycle after release behaves as IDLE.

Verification
REQ-035 Combinational dmem: req=1, cs_n=2'b10, slv_rvalid=2'b01, dmem data 0x12345678 at cycle 0 -> cycle 1: rvalid=1, rerr=0, rdata=0x12345678, busy=1; cycle 2: busy=0.
REQ-036 Delayed TBMAN: req with cs_n=2'b01; slv_rvalid[1] at cycle 3 with 0xCAFE0001; slv_rvalid[0] pulsed at cycle 2 -> cycle 2 pulse ignored; rvalid at cycle 4, rdata=0xCAFE0001, rerr=0.
REQ-037 Both selects low (cs_n=2'b00), both valid, data 0xA / 0xB -> rdata=0xA; TBMAN data ignored.
REQ-038 No select: req with cs_n=2'b11 -> cycle 1: rvalid=1, rerr=1, rdata=ERR_DATA.
REQ-039 Timeout, TIMEOUT=15, no valid -> rvalid=rerr=1 at cycle 16; with valid at cycle 15 instead -> data response at cycle 16, rerr=0.
REQ-040 Reset in WAIT: rst_n low at cycle 2 for 2 cycles, slave valid afterward -> no rvalid; next req is served normally.
